ifetch_queue: RTL
=================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL take parameter A_WIDTH, default 12: instruction address width.
REQ-002 SHALL take parameter D_WIDTH, default 8: opcode width.
REQ-003 SHALL take parameter DEPTH, default 4: prefetch queue entries, power of two, minimum 2.
REQ-004 SHALL take parameter RESET_PC, default 0: first fetch address after reset.
REQ-005 SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  clock; all state on the rising edge.
- reset  input  1  asynchronous active-low reset; low holds the block in reset.
REQ-006 SHALL have the following remaining ports:
- redirect  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  A_WIDTH  new fetch address.
- ice  output  1  instruction memory read enable.
- ia  output  A_WIDTH  instruction memory address.
- id  input  D_WIDTH  read data, valid the cycle after ice.
- opcode  output  D_WIDTH  queue head opcode.
- opcode_pc  output  A_WIDTH  address of the queue head opcode.
- opcode_valid  output  1  queue non-empty.
- ack_in  input  1  consumer takes the head this cycle.
- level  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-007 SHALL treat memory as synchronous: ice=1 with ia=A in cycle N means id holds mem[A] in cycle N+1.
REQ-008 SHALL hold an internal fetch_pc and one in-flight flag with its address (inflight_v, inflight_pc).
REQ-009 SHALL, without redirect, drive ice=1 and ia=fetch_pc iff level + inflight_v < DEPTH; fetch_pc then increments by 1, modulo 2^A_WIDTH (wrap from all-ones to 0).
REQ-010 SHALL, when inflight_v=1, write id and inflight_pc into the queue tail at the end of that cycle; the entry is visible at the head no earlier than the following cycle (no bypass); first-fetch-to-opcode_valid latency = 2 cycles.
REQ-011 SHALL pop the head when opcode_valid=1 and ack_in=1; ack_in with opcode_valid=0 SHALL be ignored.
REQ-012 SHALL support a simultaneous write and pop with level unchanged, including at level=DEPTH-1 and at level=1.
REQ-013 SHALL never write when full; REQ-009 guarantees this, and an assertion SHALL check it.
REQ-014 SHALL, on a cycle with redirect=1:
- drive ice=1 and ia=redirect_pc;
- clear the queue (level=0 next cycle), ignoring any pop;
- discard the data of the old in-flight fetch;
- mark the new access in flight with inflight_pc=redirect_pc;
- set fetch_pc=redirect_pc+1.
This gives zero bubble beyond the REQ-010 latency.
REQ-015 SHALL give redirect priority over pop, write and normal issue when they occur in the same cycle.
REQ-016 SHALL keep opcode and opcode_pc stable while opcode_valid=1 and no pop or redirect occurs.
REQ-017 SHALL present undefined-but-stable opcode and opcode_pc values when opcode_valid=0; consumers SHALL NOT use them.

Reset
REQ-018 SHALL, while reset is low, asynchronously force: ice=0, level=0, opcode_valid=0, inflight_v=0, fetch_pc=RESET_PC, opcode=0, opcode_pc=0.
REQ-019 SHALL issue its first fetch (ia=RESET_PC) in the first cycle after reset goes high.
REQ-020 SHALL, when reset is asserted mid-operation, discard all queue contents and in-flight data.
REQ-021 SHALL, when reset rises, go high synchronously to clk at integration (this block does not synchronise it).

Structure
REQ-022 SHALL take the default A_WIDTH, D_WIDTH, DEPTH and RESET_PC values from the shared package ifetch_pkg.
REQ-023 SHALL place queue storage and pointers in one sub-module, ifetch_fifo:
- parametrised width = A_WIDTH+D_WIDTH, depth = DEPTH;
- ports: push, pop, flush, level, head data.
REQ-024 SHALL keep the issue and redirect logic in ifetch_queue itself.

Verification
REQ-025 Reset release, memory mem[i]=i+0x10, ack_in=0 -> ice high in cycles 1..4 with ia=0,1,2,3; then ice=0; level=4; opcode=0x10, opcode_pc=0.
REQ-026 Steady flow, ack_in=1 constantly -> one opcode per cycle from cycle 3 on, opcode_pc sequence 0,1,2,... with no gaps; level never exceeds DEPTH.
REQ-027 Redirect to 0x123 while level=3 and inflight_v=1 -> same cycle ia=0x123; next cycle level=0; two cycles later opcode=mem[0x123], opcode_pc=0x123; no stale opcode appears.
REQ-028 Wrap: redirect_pc=0xFFE, ack_in=1 -> opcode_pc sequence 0xFFE, 0xFFF, 0x000, 0x001.
REQ-029 Redirect and pop in the same cycle at level=DEPTH -> pop ignored; level=0 next cycle; no further output from the old stream.
REQ-030 Reset low for one cycle mid-stream at level=2 -> ice=0 and opcode_valid=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared defaults for the instruction prefetch queue.
package ifetch_pkg;

  localparam int unsigned IFETCH_A_WIDTH  = 12;
  localparam int unsigned IFETCH_D_WIDTH  = 8;
  localparam int unsigned IFETCH_DEPTH    = 4;
  localparam int unsigned IFETCH_RESET_PC = 0;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue storage: power-of-two ring buffer with occupancy count.
// A flush empties the queue by moving the tail onto the head, so the
// head word seen while empty does not move.
module ifetch_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         dout
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_L = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (level != '0);
  assign dout   = mem[rd_ptr];

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // The issue throttle upstream must keep writes away from a full queue.
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && !flush && level == FULL_L));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetcher: issues sequential reads to a synchronous memory,
// buffers returned opcodes with their addresses, and restarts on redirect.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned A_WIDTH  = IFETCH_A_WIDTH,
  parameter int unsigned D_WIDTH  = IFETCH_D_WIDTH,
  parameter int unsigned DEPTH    = IFETCH_DEPTH,
  parameter int unsigned RESET_PC = IFETCH_RESET_PC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [A_WIDTH-1:0]       redirect_pc,
  output logic                     ice,
  output logic [A_WIDTH-1:0]       ia,
  input  logic [D_WIDTH-1:0]       id,
  output logic [D_WIDTH-1:0]       opcode,
  output logic [A_WIDTH-1:0]       opcode_pc,
  output logic                     opcode_valid,
  input  logic                     ack_in,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = A_WIDTH + D_WIDTH;
  localparam logic [LW:0] DEPTH_L = (LW+1)'(DEPTH);

  logic [A_WIDTH-1:0] fetch_pc;
  logic               inflight_v;
  logic [A_WIDTH-1:0] inflight_pc;
  logic [LW:0]        occupancy;
  logic               issue_ok;
  logic               push;
  logic               pop;
  logic [EW-1:0]      head;

  // Queue entries plus the outstanding fetch must fit in the queue.
  assign occupancy = {1'b0, level} + (LW+1)'(inflight_v);
  assign issue_ok  = occupancy < DEPTH_L;

  // Memory request: redirect always issues, otherwise throttle on space.
  assign ice = reset && (redirect || issue_ok);
  assign ia  = redirect ? redirect_pc : fetch_pc;

  // Redirect discards the old returning word and any pop.
  assign push = inflight_v && !redirect;
  assign pop  = opcode_valid && ack_in && !redirect;

  assign opcode_valid = (level != '0);
  assign opcode_pc    = head[EW-1:D_WIDTH];
  assign opcode       = head[D_WIDTH-1:0];

  // Fetch address and in-flight tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= A_WIDTH'(RESET_PC);
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc + A_WIDTH'(1);
      inflight_v  <= 1'b1;
      inflight_pc <= redirect_pc;
    end else begin
      inflight_v <= issue_ok;
      if (issue_ok) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + A_WIDTH'(1);
      end
    end
  end

  ifetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({inflight_pc, id}),
    .level (level),
    .dout  (head)
  );

endmodule
